div_recon_8bit_seq: RTL and testbench

- Sequential inverse of the team's 8-bit-by-4-bit non-restoring divider: takes a quotient, remainder and divisor and rebuilds the dividend as Q*B + R.
- Uses an iterative radix-2 shift-add over the divisor bits, one bit per cycle.
- Sits beside the divider as a self-check / reconstruction stage, with valid/ready handshakes on both sides.
- Also flags operand sets that are not a legal division result.

---
 rtl/div_recon_8bit_seq.sv | 137 +++++++++++++
 tb/tb_div_recon_8bit_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/div_recon_8bit_seq.sv
// Rebuilds a dividend from quotient, remainder and divisor (Q*B + R) by radix-2
// shift-add over the divisor bits, and flags operand sets no divider could produce.
module div_recon_8bit_seq #(
  parameter int QW = 8,
  parameter int BW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [QW-1:0]    quotient,
  input  logic [QW-1:0]    remainder,
  input  logic [BW-1:0]    divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QW+BW-1:0] dividend,
  output logic             ovf,
  output logic             rem_err,
  output logic             div_zero
);

  localparam int AW = QW + BW;
  localparam int CW = (BW > 1) ? $clog2(BW) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] q_q, q_d;
  logic [BW-1:0] b_q, b_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] dividend_q, dividend_d;
  logic          ovf_q, ovf_d;
  logic          rem_err_q, rem_err_d;
  logic          div_zero_q, div_zero_d;
  logic [AW-1:0] sum;

  // A legal divider output never exceeds QW bits.
  function automatic logic ovf_of(input logic [AW-1:0] v);
    return |v[AW-1:QW];
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    q_d         = q_q;
    b_d         = b_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    dividend_d  = dividend_q;
    ovf_d       = ovf_q;
    rem_err_d   = rem_err_q;
    div_zero_d  = div_zero_q;
    sum         = acc_q + (b_q[0] ? q_q : '0);
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          q_d        = {{BW{1'b0}}, quotient};
          acc_d      = {{BW{1'b0}}, remainder};
          b_d        = divisor;
          cnt_d      = '0;
          div_zero_d = (divisor == '0);
          rem_err_d  = (divisor != '0) && (remainder >= {{(QW-BW){1'b0}}, divisor});
          in_ready_d = 1'b0;
          state_d    = S_CALC;
        end
      end
      S_CALC: begin
        // Divisor shifts right and quotient left, so bit cnt is always at b_q[0].
        acc_d = sum;
        q_d   = q_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(BW - 1)) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          dividend_d  = sum;
          ovf_d       = ovf_of(sum);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dividend_q  <= '0;
      ovf_q       <= 1'b0;
      rem_err_q   <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      dividend_q  <= dividend_d;
      ovf_q       <= ovf_d;
      rem_err_q   <= rem_err_d;
      div_zero_q  <= div_zero_d;
    end
  end

  // Working operands are only meaningful while CALC runs, so they need no reset.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    q_q   <= q_d;
    b_q   <= b_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign dividend  = dividend_q;
  assign ovf       = ovf_q;
  assign rem_err   = rem_err_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_div_recon_8bit_seq.sv
// Scoreboard bench for div_recon_8bit_seq: the driver queues expected results from
// an arithmetic model, a negedge monitor checks every output handshake.
module tb_div_recon_8bit_seq;

  localparam int QW = 8;
  localparam int BW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [QW-1:0]   quotient = '0;
  logic [QW-1:0]   remainder = '0;
  logic [BW-1:0]   divisor = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [QW+BW-1:0] dividend;
  logic            ovf, rem_err, div_zero;

  typedef struct {
    longint dvd;
    bit     ovf;
    bit     re;
    bit     dz;
    int     cyc;
  } exp_t;

  exp_t exp_q[$];
  int   nvec = 0;
  int   nerr = 0;
  int   cyc  = 0;

  div_recon_8bit_seq #(.QW(QW), .BW(BW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .quotient(quotient), .remainder(remainder), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready), .dividend(dividend),
    .ovf(ovf), .rem_err(rem_err), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint expv);
    nvec++;
    if (act != expv) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic exp_t model(input int q, input int r, input int b);
    exp_t e;
    e.dvd = longint'(q) * longint'(b) + longint'(r);
    e.ovf = (e.dvd > (2**QW - 1));
    e.re  = (b != 0) && (r >= b);
    e.dz  = (b == 0);
    e.cyc = 0;
    return e;
  endfunction

  // Monitor: latency on first rise, stability under backpressure, values on handshake.
  bit          pv = 1'b0, pr = 1'b0;
  longint      prev = 0;
  always @(negedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        if (!pv) chk("latency", cyc - exp_q[0].cyc, BW);
        else if (!pr) chk("hold_stable", {dividend, ovf, rem_err, div_zero}, prev);
        if (out_ready) begin
          e = exp_q.pop_front();
          chk("dividend", dividend, e.dvd);
          chk("ovf", ovf, e.ovf);
          chk("rem_err", rem_err, e.re);
          chk("div_zero", div_zero, e.dz);
        end
      end
    end
    pv   = !rst && out_valid;
    pr   = out_ready;
    prev = {dividend, ovf, rem_err, div_zero};
  end

  task automatic send(input int q, input int r, input int b, input exp_t e);
    int n = 0;
    @(posedge clk); #1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    quotient  = q[QW-1:0];
    remainder = r[QW-1:0];
    divisor   = b[BW-1:0];
    in_valid  = 1'b1;
    @(posedge clk);
    e.cyc = cyc + 1;
    exp_q.push_back(e);
    #1 in_valid = 1'b0;
  endtask

  task automatic finish_txn();
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      chk("done_timeout", 0, 1);
      return;
    end
    @(posedge clk); #1;
    chk("ready_after_hs", in_ready, 1);
    chk("valid_after_hs", out_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int q, r, b, a, n;
    // Reset with in_valid held high: nothing may be accepted.
    in_valid = 1'b1; quotient = 8'd7; remainder = 8'd1; divisor = 4'd2;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dividend", dividend, 0);
    chk("rst_flags", {ovf, rem_err, div_zero}, 0);

    out_ready = 1'b1;
    send(13, 4, 7, model(13, 4, 7));      finish_txn();
    send(255, 255, 15, model(255, 255, 15)); finish_txn();
    send(5, 3, 0, model(5, 3, 0));        finish_txn();

    // Backpressure with a competing operand set driven throughout.
    out_ready = 1'b0;
    send(20, 11, 12, model(20, 11, 12));
    quotient = 8'd9; remainder = 8'd1; divisor = 4'd3; in_valid = 1'b1;
    for (int i = 0; i < BW; i++) begin
      @(posedge clk); #1;
      chk("busy_in_ready", in_ready, 0);
    end
    chk("bp_out_valid", out_valid, 1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_ready_after_hs", in_ready, 1);
    chk("bp_valid_after_hs", out_valid, 0);

    // Reset in the second CALC cycle discards the result.
    send(100, 2, 9, model(100, 2, 9));
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_dividend", dividend, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    repeat (8) @(posedge clk);
    send(1, 0, 1, model(1, 0, 1));        finish_txn();

    // Random operands with random consumer stalls.
    for (int k = 0; k < 60; k++) begin
      q = $urandom_range(0, 255);
      r = $urandom_range(0, 255);
      b = $urandom_range(0, 15);
      send(q, r, b, model(q, r, b));
      n = 0;
      do begin
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 2) != 0);
        n++;
      end while (!in_ready && n < 100);
      if (!in_ready) chk("rand_timeout", 0, 1);
      out_ready = 1'b1;
    end

    // Round trip of every legal division: expect the original dividend back.
    for (a = 0; a < 256; a++) begin
      for (b = 1; b < 16; b++) begin
        exp_t e;
        e.dvd = a; e.ovf = 1'b0; e.re = 1'b0; e.dz = 1'b0; e.cyc = 0;
        send(a / b, a % b, b, e);
      end
    end
    repeat (20) @(posedge clk);
    chk("drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
